// File: rtl/mips_cpu_writeback_pkg.sv
// Shared types and constants for the writeback stage and its load aligner.
package wb_pkg;

  // Load kinds as issued by the memory stage
  typedef enum logic [2:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4,
    LWL = 3'd5,
    LWR = 3'd6
  } ld_type_t;

  // Merge sequencer states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RD    = 2'd1,
    S_MERGE = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True for the unaligned loads that must combine with the old register value
  function automatic logic is_merge_load(input ld_type_t t);
    return (t == LWL) || (t == LWR);
  endfunction

endpackage

// File: rtl/mips_cpu_load_align.sv
// Combinational load extension and LWL/LWR merge: picks the addressed byte or
// half out of the aligned memory word, or blends the word into the old value.
module mips_cpu_load_align
  import wb_pkg::*;
(
  input  ld_type_t    ld_type,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] ld_word,
  input  logic [31:0] old_data,
  output logic [31:0] result
);

  logic [1:0]  lwl_ofs_s;
  logic [4:0]  byte_sh_s;
  logic [4:0]  half_sh_s;
  logic [4:0]  lwl_sh_s;
  logic [31:0] word_byte_s;
  logic [31:0] word_half_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // LWL shifts by the bytes *above* the offset, LWR by the bytes below it
  assign lwl_ofs_s   = 2'd3 - ld_offset;
  assign byte_sh_s   = {ld_offset, 3'b000};
  assign half_sh_s   = {ld_offset[1], 4'b0000};
  assign lwl_sh_s    = {lwl_ofs_s, 3'b000};
  assign word_byte_s = ld_word >> byte_sh_s;
  assign word_half_s = ld_word >> half_sh_s;
  assign byte_s      = word_byte_s[7:0];
  assign half_s      = word_half_s[15:0];

  // Select extension or merge by load kind; unknown codes behave as LW
  always_comb begin
    result = ld_word;
    case (ld_type)
      LB:      result = {{24{byte_s[7]}}, byte_s};
      LBU:     result = {24'h000000, byte_s};
      LH:      result = {{16{half_s[15]}}, half_s};
      LHU:     result = {16'h0000, half_s};
      LW:      result = ld_word;
      LWL:     result = (ld_word << lwl_sh_s) |
                        (old_data & ~(32'hFFFF_FFFF << lwl_sh_s));
      LWR:     result = (ld_word >> byte_sh_s) |
                        (old_data & ~(32'hFFFF_FFFF >> byte_sh_s));
      default: result = ld_word;
    endcase
  end

endmodule

// File: rtl/mips_cpu_writeback.sv
// Writeback initiator: arbitrates ALU results and load completions onto the
// single register-file write port. LWL/LWR read the old destination value
// through read port B before writing the merged word.
module mips_cpu_writeback
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_dest,
  input  ld_type_t          ld_type,
  input  logic [1:0]        ld_offset,
  input  logic [DATA_W-1:0] ld_word,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              writeEnable,
  output logic [ADDR_W-1:0] writeAddress,
  output logic [DATA_W-1:0] dataIn,
  output logic              busy
);

  state_t            state_r;
  state_t            state_n_s;
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [DATA_W-1:0] wr_data_r;
  logic [ADDR_W-1:0] rd_addr_r;
  ld_type_t          lat_type_r;
  logic [1:0]        lat_ofs_r;
  logic [DATA_W-1:0] lat_word_r;

  logic              idle_s;
  logic              ld_accept_s;
  logic              alu_accept_s;
  logic              ld_merge_s;
  ld_type_t          align_type_s;
  logic [1:0]        align_ofs_s;
  logic [DATA_W-1:0] align_word_s;
  logic [DATA_W-1:0] align_result_s;

  // Loads are older than the ALU op in flight, so they win the port
  assign idle_s       = (state_r == S_IDLE);
  assign ld_ready     = idle_s;
  assign alu_ready    = idle_s & ~ld_valid;
  assign ld_accept_s  = ld_valid & ld_ready;
  assign alu_accept_s = alu_valid & alu_ready;
  assign ld_merge_s   = is_merge_load(ld_type);

  // Aligner sees the live load while idle and the latched one while merging
  always_comb begin
    align_type_s = ld_type;
    align_ofs_s  = ld_offset;
    align_word_s = ld_word;
    if (state_r == S_MERGE) begin
      align_type_s = lat_type_r;
      align_ofs_s  = lat_ofs_r;
      align_word_s = lat_word_r;
    end else begin
      align_type_s = ld_type;
      align_ofs_s  = ld_offset;
      align_word_s = ld_word;
    end
  end

  mips_cpu_load_align u_align (
    .ld_type   (align_type_s),
    .ld_offset (align_ofs_s),
    .ld_word   (align_word_s),
    .old_data  (rf_read_data),
    .result    (align_result_s)
  );

  // Next-state logic; a merge to r0 is swallowed without a read
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (ld_accept_s && ld_merge_s && (ld_dest != REG_ZERO)) begin
          state_n_s = S_RD;
        end else begin
          state_n_s = S_IDLE;
        end
      end
      S_RD:    state_n_s = S_MERGE;
      S_MERGE: state_n_s = S_IDLE;
      default: state_n_s = S_IDLE;
    endcase
  end

  // State, request latch and registered write port
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= REG_ZERO;
      wr_data_r  <= 32'h0000_0000;
      rd_addr_r  <= REG_ZERO;
      lat_type_r <= LW;
      lat_ofs_r  <= 2'd0;
      lat_word_r <= 32'h0000_0000;
    end else begin
      state_r <= state_n_s;
      wr_en_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (ld_accept_s) begin
            if (ld_merge_s) begin
              if (ld_dest != REG_ZERO) begin
                rd_addr_r  <= ld_dest;
                lat_type_r <= ld_type;
                lat_ofs_r  <= ld_offset;
                lat_word_r <= ld_word;
              end
            end else begin
              wr_en_r   <= (ld_dest != REG_ZERO);
              wr_addr_r <= ld_dest;
              wr_data_r <= align_result_s;
            end
          end else if (alu_accept_s) begin
            wr_en_r   <= (alu_dest != REG_ZERO);
            wr_addr_r <= alu_dest;
            wr_data_r <= alu_data;
          end
        end
        S_MERGE: begin
          wr_en_r   <= 1'b1;
          wr_addr_r <= rd_addr_r;
          wr_data_r <= align_result_s;
        end
        default: ;
      endcase
    end
  end

  assign writeEnable  = wr_en_r;
  assign writeAddress = wr_addr_r;
  assign dataIn       = wr_data_r;
  assign rf_read_addr = rd_addr_r;
  assign busy         = ~idle_s;

endmodule

// File: tb/tb_mips_cpu_writeback.sv
// Directed bench for mips_cpu_writeback with a small register-file model.
module tb_mips_cpu_writeback;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_dest;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_dest;
  ld_type_t    ld_type;
  logic [1:0]  ld_offset;
  logic [31:0] ld_word;
  logic [4:0]  rf_read_addr;
  logic [31:0] rf_read_data = 32'h0000_0000;
  logic        writeEnable;
  logic [4:0]  writeAddress;
  logic [31:0] dataIn;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] regs [32] = '{default: 32'h0000_0000};

  mips_cpu_writeback dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_dest     (alu_dest),
    .alu_data     (alu_data),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_dest      (ld_dest),
    .ld_type      (ld_type),
    .ld_offset    (ld_offset),
    .ld_word      (ld_word),
    .rf_read_addr (rf_read_addr),
    .rf_read_data (rf_read_data),
    .writeEnable  (writeEnable),
    .writeAddress (writeAddress),
    .dataIn       (dataIn),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Register file: registered read port B, write port fed by the DUT
  always @(posedge clk) begin
    rf_read_data <= regs[rf_read_addr];
    if (writeEnable) regs[writeAddress] <= dataIn;
  end

  typedef struct {
    string       name;
    logic        is_ld;
    logic [4:0]  dest;
    ld_type_t    typ;
    logic [1:0]  ofs;
    logic [31:0] word;
    logic        exp_we;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_dest = 5'd0; alu_data = 32'h0000_0000;
    ld_valid = 1'b0; ld_dest = 5'd0; ld_type = LW; ld_offset = 2'd0;
    ld_word = 32'h0000_0000;
  endtask

  task automatic alu_write(input logic [4:0] d, input logic [31:0] v);
    alu_valid = 1'b1; alu_dest = d; alu_data = v;
    tick();
    alu_valid = 1'b0;
    chk("preload_we", {31'd0, writeEnable}, 32'd1);
    chk("preload_data", dataIn, v);
  endtask

  // Full LWL/LWR sequence with a queued ALU op that must wait for the merge
  task automatic merge_seq(input string nm, input ld_type_t t, input logic [4:0] d,
                           input logic [1:0] o, input logic [31:0] w,
                           input logic [31:0] exp);
    ld_valid = 1'b1; ld_dest = d; ld_type = t; ld_offset = o; ld_word = w;
    #1;
    chk({nm, "_accept_ready"}, {31'd0, ld_ready}, 32'd1);
    tick();
    ld_valid = 1'b0;
    alu_valid = 1'b1; alu_dest = 5'd21; alu_data = exp ^ 32'h5A5A_5A5A;
    #1;
    chk({nm, "_rd_busy"}, {31'd0, busy}, 32'd1);
    chk({nm, "_rd_addr"}, {27'd0, rf_read_addr}, {27'd0, d});
    chk({nm, "_rd_we"}, {31'd0, writeEnable}, 32'd0);
    chk({nm, "_rd_ld_ready"}, {31'd0, ld_ready}, 32'd0);
    chk({nm, "_rd_alu_ready"}, {31'd0, alu_ready}, 32'd0);
    tick();
    chk({nm, "_mg_busy"}, {31'd0, busy}, 32'd1);
    chk({nm, "_mg_we"}, {31'd0, writeEnable}, 32'd0);
    chk({nm, "_mg_alu_ready"}, {31'd0, alu_ready}, 32'd0);
    tick();
    chk({nm, "_wr_we"}, {31'd0, writeEnable}, 32'd1);
    chk({nm, "_wr_addr"}, {27'd0, writeAddress}, {27'd0, d});
    chk({nm, "_wr_data"}, dataIn, exp);
    chk({nm, "_wr_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_wr_alu_ready"}, {31'd0, alu_ready}, 32'd1);
    tick();
    alu_valid = 1'b0;
    chk({nm, "_alu_after_we"}, {31'd0, writeEnable}, 32'd1);
    chk({nm, "_alu_after_addr"}, {27'd0, writeAddress}, 32'd21);
    chk({nm, "_alu_after_data"}, dataIn, exp ^ 32'h5A5A_5A5A);
  endtask

  initial begin
    vecs[0]  = '{"alu_d8",     1'b0, 5'd8,  LW,  2'd0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
    vecs[1]  = '{"lb_o2",      1'b1, 5'd9,  LB,  2'd2, 32'h0080_FF00, 1'b1, 32'hFFFF_FF80};
    vecs[2]  = '{"lbu_o1",     1'b1, 5'd11, LBU, 2'd1, 32'h0080_FF00, 1'b1, 32'h0000_00FF};
    vecs[3]  = '{"lb_o3_pos",  1'b1, 5'd12, LB,  2'd3, 32'h7F00_0000, 1'b1, 32'h0000_007F};
    vecs[4]  = '{"lhu_o2",     1'b1, 5'd13, LHU, 2'd2, 32'h8001_ABCD, 1'b1, 32'h0000_8001};
    vecs[5]  = '{"lh_o0",      1'b1, 5'd14, LH,  2'd0, 32'h8001_ABCD, 1'b1, 32'hFFFF_ABCD};
    vecs[6]  = '{"lh_o3",      1'b1, 5'd15, LH,  2'd3, 32'h8001_ABCD, 1'b1, 32'hFFFF_8001};
    vecs[7]  = '{"lw_o1",      1'b1, 5'd16, LW,  2'd1, 32'h1234_5678, 1'b1, 32'h1234_5678};
    vecs[8]  = '{"type7",      1'b1, 5'd17, ld_type_t'(3'd7), 2'd2, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D};
    vecs[9]  = '{"alu_d0",     1'b0, 5'd0,  LW,  2'd0, 32'h0BAD_0BAD, 1'b0, 32'h0000_0000};
    vecs[10] = '{"lbu_d0",     1'b1, 5'd0,  LBU, 2'd0, 32'h0000_00AA, 1'b0, 32'h0000_0000};

    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_we", {31'd0, writeEnable}, 32'd0);
    chk("rst_waddr", {27'd0, writeAddress}, 32'd0);
    chk("rst_data", dataIn, 32'd0);
    chk("rst_raddr", {27'd0, rf_read_addr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    #1;
    chk("idle_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("idle_alu_ready", {31'd0, alu_ready}, 32'd1);

    // Single-cycle transactions from the table
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].is_ld) begin
        ld_valid = 1'b1; ld_dest = vecs[i].dest; ld_type = vecs[i].typ;
        ld_offset = vecs[i].ofs; ld_word = vecs[i].word;
      end else begin
        alu_valid = 1'b1; alu_dest = vecs[i].dest; alu_data = vecs[i].word;
      end
      tick();
      idle_inputs();
      chk({vecs[i].name, "_we"}, {31'd0, writeEnable}, {31'd0, vecs[i].exp_we});
      if (vecs[i].exp_we) begin
        chk({vecs[i].name, "_addr"}, {27'd0, writeAddress}, {27'd0, vecs[i].dest});
        chk({vecs[i].name, "_data"}, dataIn, vecs[i].exp_data);
      end
      tick();
      chk({vecs[i].name, "_one_shot"}, {31'd0, writeEnable}, 32'd0);
    end

    // Same-cycle ALU and load: load wins, ALU follows
    alu_valid = 1'b1; alu_dest = 5'd20; alu_data = 32'h55AA_55AA;
    ld_valid = 1'b1; ld_dest = 5'd9; ld_type = LB; ld_offset = 2'd2; ld_word = 32'h0080_FF00;
    #1;
    chk("arb_alu_ready", {31'd0, alu_ready}, 32'd0);
    chk("arb_ld_ready", {31'd0, ld_ready}, 32'd1);
    tick();
    ld_valid = 1'b0;
    chk("arb_ld_addr", {27'd0, writeAddress}, 32'd9);
    chk("arb_ld_data", dataIn, 32'hFFFF_FF80);
    #1;
    chk("arb_alu_ready2", {31'd0, alu_ready}, 32'd1);
    tick();
    alu_valid = 1'b0;
    chk("arb_alu_we", {31'd0, writeEnable}, 32'd1);
    chk("arb_alu_addr", {27'd0, writeAddress}, 32'd20);
    chk("arb_alu_data", dataIn, 32'h55AA_55AA);

    // Merge loads against known old values
    alu_write(5'd10, 32'h1122_3344);
    alu_write(5'd11, 32'h1122_3344);
    alu_write(5'd12, 32'h0F0F_0F0F);
    alu_write(5'd13, 32'hF0F0_F0F0);
    tick();
    merge_seq("lwl_o1", LWL, 5'd10, 2'd1, 32'hAABB_CCDD, 32'hCCDD_3344);
    merge_seq("lwr_o2", LWR, 5'd11, 2'd2, 32'hAABB_CCDD, 32'h1122_AABB);
    merge_seq("lwl_o3", LWL, 5'd12, 2'd3, 32'hAABB_CCDD, 32'hAABB_CCDD);
    merge_seq("lwr_o0", LWR, 5'd13, 2'd0, 32'h1357_9BDF, 32'h1357_9BDF);
    merge_seq("lwl_o0", LWL, 5'd10, 2'd0, 32'hAABB_CCDD, 32'hDDDD_3344);

    // Merge to r0: accepted, no read, no write
    ld_valid = 1'b1; ld_dest = 5'd0; ld_type = LWL; ld_offset = 2'd1; ld_word = 32'hAABB_CCDD;
    #1;
    chk("z_ready", {31'd0, ld_ready}, 32'd1);
    tick();
    ld_valid = 1'b0;
    chk("z_busy", {31'd0, busy}, 32'd0);
    chk("z_we", {31'd0, writeEnable}, 32'd0);
    tick();
    chk("z_we2", {31'd0, writeEnable}, 32'd0);
    chk("z_busy2", {31'd0, busy}, 32'd0);

    // Reset while in S_MERGE drops the pending write
    ld_valid = 1'b1; ld_dest = 5'd10; ld_type = LWL; ld_offset = 2'd0; ld_word = 32'h9999_9999;
    tick();
    ld_valid = 1'b0;
    tick();
    chk("rm_busy_merge", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    chk("rm_busy", {31'd0, busy}, 32'd0);
    chk("rm_we", {31'd0, writeEnable}, 32'd0);
    chk("rm_waddr", {27'd0, writeAddress}, 32'd0);
    chk("rm_raddr", {27'd0, rf_read_addr}, 32'd0);
    reset = 1'b0;
    tick();
    chk("rm_we2", {31'd0, writeEnable}, 32'd0);
    chk("rm_busy2", {31'd0, busy}, 32'd0);
    chk("rm_reg10_kept", regs[10], 32'hDDDD_3344);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
